cs_bernoulli_encoder: RTL

Streaming compressed-sensing measurement block: accepts N unsigned fixed-point samples per frame and computes M measurements y = Φx, where Φ is an M×N ±1 Bernoulli matrix generated on the fly by a 32-bit LFSR. The LFSR is reseeded every frame, so Φ is identical from frame to frame and a reconstruction engine can regenerate it. The block is the parametrised successor of the single-channel 16-bit Q3.13 sample processor. It sits between the sample front end and the measurement transmit path.

---
 rtl/cs_bernoulli_encoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cs_bernoulli_encoder.sv
// Compressed-sensing encoder: accumulates y = Phi*x over N samples per frame,
// where Phi is an M x N +/-1 matrix produced on the fly by a Galois LFSR that is
// reseeded each frame, then drains the M measurements one per cycle.
module cs_bernoulli_encoder #(
    parameter int          DATA_W = 16,
    parameter int          FRAC_W = 13,
    parameter int          N      = 64,
    parameter int          M      = 16,
    parameter logic [31:0] SEED   = 32'hACE1_2B35,
    parameter int          ACC_W  = DATA_W + 1 + $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_W-1:0]       d_in,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] d_out,
    output logic                    out_valid,
    output logic                    flag_out
);

    localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
    localparam int               CNT_W     = $clog2(N);
    localparam int               ROW_W     = (M > 1) ? $clog2(M) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(M - 1);

    // d_out carries the input binary point unchanged (FRAC_W fractional bits).
    if (FRAC_W > DATA_W || SEED == 32'd0 || M < 1 || M > 32 || N < 2) begin : g_bad_params
        $error("cs_bernoulli_encoder: invalid parameter set");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [ROW_W-1:0]        row;
    logic [31:0]             lfsr;
    logic signed [ACC_W-1:0] acc_p0 [M];
    logic                    accept;
    logic                    last_sample;
    logic                    last_row;

    // Zero-extended sample, added or subtracted according to the Phi sign bit.
    function automatic logic signed [ACC_W-1:0] signed_term(input logic sgn,
                                                            input logic [DATA_W-1:0] x);
        logic signed [ACC_W-1:0] mag;
        mag = $signed({{(ACC_W-DATA_W){1'b0}}, x});
        return sgn ? mag : -mag;
    endfunction

    // One Galois step, x^32+x^22+x^2+x+1, shifting right.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    assign accept      = en && in_ready;
    assign last_sample = accept && (cnt == CNT_LAST);
    assign last_row    = (state == DRAIN) && (row == ROW_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACCUM;
        else      state <= state_nxt;
    end

    // Next-state logic: leave ACCUM on the final sample, leave DRAIN on the final row.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (last_sample) state_nxt = DRAIN;
            DRAIN:   if (last_row)    state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Frame control: input handshake, sample/row counters and the Phi generator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b1;
            cnt      <= '0;
            row      <= '0;
            lfsr     <= SEED;
        end else begin
            if (last_sample)   in_ready <= 1'b0;
            else if (last_row) in_ready <= 1'b1;

            if (last_sample || last_row) cnt <= '0;
            else if (accept)             cnt <= cnt + CNT_W'(1);

            if (last_row)              row <= '0;
            else if (state == DRAIN)   row <= row + ROW_W'(1);

            if (last_row)    lfsr <= SEED;
            else if (accept) lfsr <= lfsr_step(lfsr);
        end
    end

    // Stage p0: per-row accumulation, signs taken from the LFSR before it advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < M; i++) acc_p0[i] <= '0;
        end else if (last_row) begin
            for (int i = 0; i < M; i++) acc_p0[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < M; i++) acc_p0[i] <= acc_p0[i] + signed_term(lfsr[i], d_in);
        end
    end

    // Stage p1: registered measurement output, one row per DRAIN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out     <= '0;
            out_valid <= 1'b0;
            flag_out  <= 1'b0;
        end else begin
            out_valid <= (state == DRAIN);
            flag_out  <= last_row;
            if (state == DRAIN) d_out <= acc_p0[row];
        end
    end

endmodule
